// File: rtl/pcie_tlp_packet_dec.sv
// Single-beat 3DW TLP decoder: MRd becomes a read_req pulse followed by a guard window, MWr becomes a held mem_write_req.
// Optional drop counter: define PCIE_TLP_DEC_DROPCNT_EN to build it; otherwise drop_cnt is tied to 0.
module pcie_tlp_packet_dec #(
   parameter int RD_GUARD_CYCLES = 13,
   parameter int WR_TIMEOUT      = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_sop,
   input  logic         rx_eop,
   input  logic [255:0] rx_data,
   input  logic [7:0]   rx_valid,
   output logic         rx_ready,
   output logic         read_req,
   output logic [15:0]  read_addr,
   output logic [3:0]   bit_enable,
   output logic [7:0]   tag,
   output logic [15:0]  RequesterID,
   output logic         mem_write_req,
   output logic [15:0]  mem_write_addr,
   output logic [31:0]  mem_write_data,
   output logic [3:0]   mem_write_be,
   input  logic         mem_write_ack,
   output logic [7:0]   drop_cnt,
   output logic [1:0]   dbg_state
);

   localparam int GW = (RD_GUARD_CYCLES > 1) ? $clog2(RD_GUARD_CYCLES) : 1;
   localparam int WW = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_ISSUE = 2'd1,
      RD_GUARD = 2'd2,
      WR_WAIT  = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [GW-1:0] r_guard_cnt, w_guard_nxt;
   logic [WW-1:0] r_wr_cnt, w_wr_nxt;
   logic          r_skip;

   logic [15:0]   r_read_addr, r_req_id, r_wr_addr;
   logic [3:0]    r_bit_enable, r_wr_be;
   logic [7:0]    r_tag;
   logic [31:0]   r_wr_data;

   logic [7:0]    w_fmt_type;
   logic [9:0]    w_length;
   logic          w_is_mrd, w_is_mwr, w_sop_live, w_accept;
   logic          w_acc_rd, w_acc_wr, w_wr_expire;
   logic          w_unused;

   // Handshake: a beat transfers on a clock edge where rx_ready, rx_sop, rx_eop
   // and rx_valid[7:5] are all high; rx_ready depends only on state and rst.
   assign rx_ready    = (r_state == IDLE) && !rst;
   assign w_fmt_type  = rx_data[255:248];
   assign w_length    = rx_data[233:224];
   assign w_is_mrd    = (w_fmt_type == 8'h00) && (w_length == 10'd1);
   assign w_is_mwr    = (w_fmt_type == 8'h40) && (w_length == 10'd1) && rx_valid[4];
   // r_skip hides the tail of a dropped multi-beat TLP until its rx_eop
   assign w_sop_live  = rx_sop && !r_skip;
   assign w_accept    = rx_ready && w_sop_live && rx_eop && (&rx_valid[7:5]);
   assign w_acc_rd    = w_accept && w_is_mrd;
   assign w_acc_wr    = w_accept && w_is_mwr;
   assign w_wr_expire = (r_state == WR_WAIT) && !mem_write_ack &&
                        (r_wr_cnt == WW'(WR_TIMEOUT - 1));
   assign w_unused    = ^{rx_data[247:234], rx_data[199:196], rx_data[191:176],
                          rx_data[127:0], rx_valid[3:0]};

   always_comb begin
      w_state_nxt = r_state;
      w_guard_nxt = r_guard_cnt;
      w_wr_nxt    = r_wr_cnt;
      case (r_state)
         IDLE: begin
            if (w_acc_rd) begin
               w_state_nxt = RD_ISSUE;
            end else if (w_acc_wr) begin
               w_state_nxt = WR_WAIT;
               w_wr_nxt    = '0;
            end
         end
         RD_ISSUE: begin
            w_state_nxt = RD_GUARD;
            w_guard_nxt = GW'(RD_GUARD_CYCLES - 1);
         end
         RD_GUARD: begin
            // leaving as the count reaches 0 keeps rx_ready low for exactly
            // RD_GUARD_CYCLES cycles counting the issue cycle
            if (r_guard_cnt <= GW'(1)) begin
               w_state_nxt = IDLE;
               w_guard_nxt = '0;
            end else begin
               w_guard_nxt = r_guard_cnt - GW'(1);
            end
         end
         WR_WAIT: begin
            if (mem_write_ack || w_wr_expire) begin
               w_state_nxt = IDLE;
            end else begin
               w_wr_nxt = r_wr_cnt + WW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_guard_cnt <= '0;
         r_wr_cnt    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_guard_cnt <= w_guard_nxt;
         r_wr_cnt    <= w_wr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_skip <= 1'b0;
      end else if (r_skip && rx_eop) begin
         r_skip <= 1'b0;
      end else if (w_sop_live && !rx_eop) begin
         r_skip <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_read_addr  <= '0;
         r_bit_enable <= '0;
         r_tag        <= '0;
         r_req_id     <= '0;
      end else if (w_acc_rd) begin
         r_read_addr  <= rx_data[175:160];
         r_bit_enable <= rx_data[195:192];
         r_tag        <= rx_data[207:200];
         r_req_id     <= rx_data[223:208];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_wr_be   <= '0;
      end else if (w_acc_wr) begin
         r_wr_addr <= rx_data[175:160];
         r_wr_data <= rx_data[159:128];
         r_wr_be   <= rx_data[195:192];
      end
   end

   assign read_req       = (r_state == RD_ISSUE) && !rst;
   assign mem_write_req  = (r_state == WR_WAIT) && !rst;
   assign read_addr      = rst ? 16'h0 : r_read_addr;
   assign bit_enable     = rst ? 4'h0  : r_bit_enable;
   assign tag            = rst ? 8'h0  : r_tag;
   assign RequesterID    = rst ? 16'h0 : r_req_id;
   assign mem_write_addr = rst ? 16'h0 : r_wr_addr;
   assign mem_write_data = rst ? 32'h0 : r_wr_data;
   assign mem_write_be   = rst ? 4'h0  : r_wr_be;
   assign dbg_state      = r_state;

`ifdef PCIE_TLP_DEC_DROPCNT_EN
   logic       w_rx_drop;
   logic [1:0] w_drop_inc;
   logic [8:0] w_drop_sum;
   logic [7:0] r_drop_cnt;

   // a header refusal and a write timeout can land on the same edge
   assign w_rx_drop  = w_sop_live && !(w_acc_rd || w_acc_wr);
   assign w_drop_inc = {1'b0, w_rx_drop} + {1'b0, w_wr_expire};
   assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_drop_inc};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else begin
         r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
   end

   assign drop_cnt = rst ? 8'h00 : r_drop_cnt;
`else
   assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pcie_tlp_packet_dec.sv
// Bench for pcie_tlp_packet_dec: table of directed TLPs, reset/multi-beat/saturation sequences, then random TLPs against a transaction-level model.
module tb_pcie_tlp_packet_dec;

   localparam int GUARD = 13;
   localparam int TMO   = 255;
`ifdef PCIE_TLP_DEC_DROPCNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif
   localparam int K_DROP = 0;
   localparam int K_RD   = 1;
   localparam int K_WR   = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         rx_sop, rx_eop;
   logic [255:0] rx_data;
   logic [7:0]   rx_valid;
   logic         rx_ready, read_req, mem_write_req, mem_write_ack;
   logic [15:0]  read_addr, RequesterID, mem_write_addr;
   logic [3:0]   bit_enable, mem_write_be;
   logic [7:0]   tag, drop_cnt;
   logic [31:0]  mem_write_data;
   logic [1:0]   dbg_state;

   pcie_tlp_packet_dec #(.RD_GUARD_CYCLES(GUARD), .WR_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .read_req(read_req),
      .read_addr(read_addr), .bit_enable(bit_enable), .tag(tag),
      .RequesterID(RequesterID), .mem_write_req(mem_write_req),
      .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
      .mem_write_be(mem_write_be), .mem_write_ack(mem_write_ack),
      .drop_cnt(drop_cnt), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dw0, dw1, dw2, dw3;
      logic [7:0]  valid;
      int          ack_delay;   // 0 = never acknowledge
      int          kind;
      logic [15:0] addr;
      logic [3:0]  be;
      logic [7:0]  tag;
      logic [15:0] rid;
      logic [31:0] data;
   } tv_t;

   tv_t         tv[10];
   int          vectors = 0;
   int          miscompares = 0;
   int          exp_drops = 0;
   int          rd_total = 0;
   logic [63:0] exp_q[$];

   always @(negedge clk) if (read_req === 1'b1) rd_total++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] exp_drop_cnt();
      if (!DROP_EN) return 64'd0;
      return (exp_drops > 255) ? 64'd255 : 64'(exp_drops);
   endfunction

   // Reference: decide the fate of a single-beat TLP from the header rules.
   function automatic tv_t model(input tv_t v);
      tv_t r = v;
      logic [7:0] fmt = v.dw0[31:24];
      if (v.valid[7:5] != 3'b111 || v.dw0[9:0] != 10'd1) r.kind = K_DROP;
      else if (fmt == 8'h00) r.kind = K_RD;
      else if (fmt == 8'h40 && v.valid[4]) r.kind = K_WR;
      else r.kind = K_DROP;
      r.addr = v.dw2[15:0];
      r.be   = v.dw1[3:0];
      r.tag  = v.dw1[15:8];
      r.rid  = v.dw1[31:16];
      r.data = v.dw3;
      return r;
   endfunction

   task automatic drive(input tv_t v, input logic sop, input logic eop);
      rx_data  = {v.dw0, v.dw1, v.dw2, v.dw3, 128'h0};
      rx_valid = v.valid;
      rx_sop   = sop;
      rx_eop   = eop;
   endtask

   task automatic idle_inputs();
      rx_sop = 1'b0; rx_eop = 1'b0; rx_valid = 8'h00; rx_data = '0;
   endtask

   // Entered and left just after a rising edge; DUT expected to be idle.
   task automatic do_tlp(input string nm, input tv_t v);
      int   cyc = 0;
      int   pulses = 0;
      int   bad = 0;
      int   exp_high;
      bit   done = 0;
      logic ready_after = 1'b0;
      drive(v, 1'b1, 1'b1);
      @(negedge clk);
      check({nm, "_ready"}, 64'(rx_ready), 64'd1);
      @(posedge clk); #1;
      idle_inputs();
      if (v.kind == K_RD) begin
         exp_q.push_back({20'h0, v.rid, v.tag, v.be, v.addr});
         while (!done && cyc < 400) begin
            @(negedge clk);
            if (rx_ready) done = 1;
            else begin
               cyc++;
               if (read_req) begin
                  pulses++;
                  check({nm, "_rd_latency"}, 64'(cyc), 64'd1);
                  if (exp_q.size() > 0)
                     check({nm, "_rd_fields"}, {20'h0, RequesterID, tag, bit_enable, read_addr},
                           exp_q.pop_front());
               end
            end
            @(posedge clk); #1;
         end
         exp_q.delete();
         check({nm, "_rd_pulses"}, 64'(pulses), 64'd1);
         check({nm, "_busy_cycles"}, 64'(cyc), 64'(GUARD));
      end else if (v.kind == K_WR) begin
         exp_high = (v.ack_delay == 0 || v.ack_delay > TMO) ? TMO : v.ack_delay;
         while (!done && cyc < 400) begin
            @(negedge clk);
            if (!mem_write_req) begin
               done = 1;
               ready_after = rx_ready;
            end else begin
               cyc++;
               if ({mem_write_addr, mem_write_data, mem_write_be} !== {v.addr, v.data, v.be}) bad++;
               if (read_req) bad++;
               if (cyc == v.ack_delay) mem_write_ack = 1'b1;
            end
            @(posedge clk); #1;
            mem_write_ack = 1'b0;
         end
         if (exp_high == TMO) exp_drops++;
         check({nm, "_wr_high"}, 64'(cyc), 64'(exp_high));
         check({nm, "_wr_fields_bad"}, 64'(bad), 64'd0);
         check({nm, "_ready_after_wr"}, 64'(ready_after), 64'd1);
      end else begin
         @(negedge clk);
         check({nm, "_drop_quiet"}, {61'h0, rx_ready, read_req, mem_write_req}, 64'd4);
         exp_drops++;
         @(posedge clk); #1;
      end
      check({nm, "_drop_cnt"}, 64'(drop_cnt), exp_drop_cnt());
   endtask

   initial begin
      tv_t r;
      int  rd0;
      int  guard_wait;
      logic [7:0] fmts[7];
      logic [7:0] valids[6];

      tv[0] = '{32'h00000001, 32'h11002A0F, 32'h00000034, 32'h0, 8'hE0, 0, K_RD,
                16'h0034, 4'hF, 8'h2A, 16'h1100, 32'h0};
      tv[1] = '{32'h40000001, 32'h00000001, 32'h00000010, 32'hDEADBEEF, 8'hF0, 4, K_WR,
                16'h0010, 4'h1, 8'h00, 16'h0000, 32'hDEADBEEF};
      tv[2] = '{32'h00000002, 32'h11002A0F, 32'h00000034, 32'h0, 8'hE0, 0, K_DROP,
                16'h0, 4'h0, 8'h0, 16'h0, 32'h0};
      tv[3] = '{32'h4A000001, 32'h0, 32'h0, 32'h0, 8'hF0, 0, K_DROP,
                16'h0, 4'h0, 8'h0, 16'h0, 32'h0};
      tv[4] = '{32'h40000001, 32'h00000001, 32'h00000010, 32'hDEADBEEF, 8'hE0, 4, K_DROP,
                16'h0, 4'h0, 8'h0, 16'h0, 32'h0};
      tv[5] = '{32'h40000001, 32'h0000000C, 32'h0000ABCD, 32'h01234567, 8'hF0, 0, K_WR,
                16'hABCD, 4'hC, 8'h0, 16'h0, 32'h01234567};
      tv[6] = '{32'h40000001, 32'h00000003, 32'h0000FFFF, 32'hCAFEF00D, 8'hFF, 1, K_WR,
                16'hFFFF, 4'h3, 8'h0, 16'h0, 32'hCAFEF00D};
      tv[7] = '{32'h00000001, 32'hBEEF7705, 32'h12348001, 32'h0, 8'hFF, 0, K_RD,
                16'h8001, 4'h5, 8'h77, 16'hBEEF, 32'h0};
      tv[8] = '{32'h00000001, 32'hBEEF7705, 32'h12348001, 32'h0, 8'hC0, 0, K_DROP,
                16'h0, 4'h0, 8'h0, 16'h0, 32'h0};
      tv[9] = '{32'h00FFFC01, 32'h00010100, 32'hFFFF5A5A, 32'h0, 8'hE0, 0, K_RD,
                16'h5A5A, 4'h0, 8'h01, 16'h0001, 32'h0};
      fmts   = '{8'h00, 8'h00, 8'h40, 8'h40, 8'h4A, 8'h60, 8'h20};
      valids = '{8'hE0, 8'hF0, 8'hFF, 8'hC0, 8'h70, 8'hF8};

      // clock/reset
      rst = 1'b1; mem_write_ack = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {61'h0, rx_ready, read_req, mem_write_req}, 64'd0);
      check("reset_drop_cnt", 64'(drop_cnt), 64'd0);
      check("reset_rd_fields", {20'h0, RequesterID, tag, bit_enable, read_addr}, 64'd0);
      check("reset_wr_fields", {12'h0, mem_write_addr, mem_write_data, mem_write_be}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 64'(rx_ready), 64'd1);
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 10; i++) do_tlp($sformatf("tv%0d", i), tv[i]);

      // multi-beat TLP is dropped once and its tail ignored
      rd0 = rd_total;
      drive(tv[0], 1'b1, 1'b0); @(posedge clk); #1;
      drive(tv[7], 1'b0, 1'b0); @(posedge clk); #1;
      drive(tv[7], 1'b0, 1'b1); @(posedge clk); #1;
      idle_inputs();
      exp_drops++;
      repeat (2) @(posedge clk); #1;
      check("multibeat_no_read", 64'(rd_total - rd0), 64'd0);
      check("multibeat_drop_cnt", 64'(drop_cnt), exp_drop_cnt());
      do_tlp("after_multibeat", tv[0]);

      // reset three cycles into the guard window
      rd0 = rd_total;
      drive(tv[7], 1'b1, 1'b1); @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midrst_ctrl", {61'h0, rx_ready, read_req, mem_write_req}, 64'd0);
      check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("midrst_rd_fields", {20'h0, RequesterID, tag, bit_enable, read_addr}, 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_drops = 0;
      @(negedge clk);
      check("midrst_ready_next", 64'(rx_ready), 64'd1);
      repeat (20) @(posedge clk); #1;
      check("midrst_single_read", 64'(rd_total - rd0), 64'd1);

      // second run: a beat arriving in the guard window is refused and counted
      rd0 = rd_total;
      drive(tv[0], 1'b1, 1'b1); @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
      drive(tv[7], 1'b1, 1'b1); @(posedge clk); #1;
      idle_inputs();
      exp_drops++;
      guard_wait = 0;
      while (!rx_ready && guard_wait < 100) begin
         @(posedge clk); #1;
         guard_wait++;
      end
      check("guard_ready_back", 64'(rx_ready), 64'd1);
      check("guard_one_read", 64'(rd_total - rd0), 64'd1);
      check("guard_fields_kept", {48'h0, read_addr}, 64'h0034);
      check("guard_drop_cnt", 64'(drop_cnt), exp_drop_cnt());

      // random TLPs against the model
      for (int n = 0; n < 40; n++) begin
         r.dw0   = {fmts[$urandom_range(0, 6)], 14'($urandom),
                    ($urandom_range(0, 4) < 4) ? 10'd1 : 10'($urandom)};
         r.dw1   = $urandom;
         r.dw2   = $urandom;
         r.dw3   = $urandom;
         r.valid = valids[$urandom_range(0, 5)];
         r.ack_delay = $urandom_range(1, 12);
         r = model(r);
         do_tlp($sformatf("rnd%0d", n), r);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      // saturation: a refused header on every cycle
      drive(tv[3], 1'b1, 1'b1);
      repeat (260) begin
         @(posedge clk); #1;
         exp_drops++;
      end
      idle_inputs();
      @(posedge clk); #1;
      check("sat_drop_cnt", 64'(drop_cnt), exp_drop_cnt());
      do_tlp("after_sat", tv[6]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
